// File: rtl/bias_buf_ctrl_pkg.sv
// Shared types and default geometry for the bias buffer controller.
package bias_buf_ctrl_pkg;

    // Default layer geometry: 16 words of 8 x 16-bit biases, 1-cycle RAM.
    localparam int DEF_DW      = 128;
    localparam int DEF_AW      = 4;
    localparam int DEF_DEPTH   = 16;
    localparam int DEF_N_DELAY = 1;

    // Controller sequence: IDLE -> LOAD -> DONE -> VALID.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_VALID = 2'd3
    } bias_state_t;

endpackage

// File: rtl/bias_buf_ctrl_if.sv
// Bundles the load stream, the bias read port and the bias RAM port.
// slave  : the controller side.
// master : the environment (DMA, conv engine, RAM wrapper).
interface bias_buf_ctrl_if #(
    parameter int DW = 128,
    parameter int AW = 4
) ();

    // Load stream from the layer DMA
    logic          load_start;
    logic [AW:0]   load_num;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          load_done;
    logic          bias_loaded;

    // Bias read port towards the conv output stage
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ready;
    logic          rd_valid;
    logic [DW-1:0] rd_data;

    // Single-port bias RAM
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  load_start, load_num, ld_valid, ld_data,
        output ld_ready, load_done, bias_loaded,
        input  rd_req, rd_addr,
        output rd_ready, rd_valid, rd_data,
        output mem_cs, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output load_start, load_num, ld_valid, ld_data,
        input  ld_ready, load_done, bias_loaded,
        output rd_req, rd_addr,
        input  rd_ready, rd_valid, rd_data,
        input  mem_cs, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/bias_buf_ctrl_rd_pipe.sv
// Read-response pipe: tracks {valid, out-of-range} for each issued read so
// the response lines up with the RAM data N_DELAY cycles later.
module bias_buf_ctrl_rd_pipe #(
    parameter int DW      = 128,
    parameter int N_DELAY = 1
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    input  logic          in_oob,
    input  logic [DW-1:0] mem_rdata,
    output logic          rd_valid,
    output logic [DW-1:0] rd_data
);

    logic [N_DELAY-1:0] valid_sr;
    logic [N_DELAY-1:0] oob_sr;

    // Shift the per-read tags along with the RAM latency.
    // NOTE: only these tag bits are reset; the RAM array itself is never
    // reset, so after reset its contents are simply stale until reloaded.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_sr <= '0;
            oob_sr   <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage sample the
            // previous stage's old value, which is what makes this a pipe.
            valid_sr[0] <= in_valid;
            oob_sr[0]   <= in_oob;
            for (int i = 1; i < N_DELAY; i++) begin
                valid_sr[i] <= valid_sr[i-1];
                oob_sr[i]   <= oob_sr[i-1];
            end
        end
    end

    assign rd_valid = valid_sr[N_DELAY-1];
    // Out-of-range reads and idle cycles present zero, never stale RAM data.
    assign rd_data  = (rd_valid && !oob_sr[N_DELAY-1]) ? mem_rdata : '0;

endmodule

// File: rtl/bias_buf_ctrl.sv
// Bias buffer controller: loads a bias table from a word stream into the
// single-port bias RAM, then serves pipelined bias reads from it. Owning the
// only RAM port means writes and reads can never collide.
module bias_buf_ctrl
    import bias_buf_ctrl_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int N_DELAY = DEF_N_DELAY
) (
    input  logic           clk,
    input  logic           rstn,
    bias_buf_ctrl_if.slave bus
);

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW:0]   ONE_N   = (AW+1)'(1);
    localparam logic [AW-1:0] ONE_A   = AW'(1);

    bias_state_t   state;
    logic [AW-1:0] wr_ptr;
    logic [AW:0]   n_lat;        // clamped word count of the load in progress
    logic [AW:0]   num_loaded;   // words valid in the current table
    logic          ld_ready_q;
    logic          load_done_q;
    logic          bias_loaded_q;

    logic          wr_fire;
    logic          rd_fire;
    logic          rd_oob;
    logic          last_wr;
    logic [AW:0]   load_clamped;

    assign wr_fire      = ld_ready_q && bus.ld_valid;
    assign rd_fire      = bias_loaded_q && bus.rd_req;
    assign rd_oob       = ({1'b0, bus.rd_addr} >= num_loaded);
    assign last_wr      = ({1'b0, wr_ptr} == (n_lat - ONE_N));
    assign load_clamped = (bus.load_num > DEPTH_W) ? DEPTH_W : bus.load_num;

    // Sequencer with registered ready/done/loaded flags.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state         <= ST_IDLE;
            wr_ptr        <= '0;
            n_lat         <= '0;
            num_loaded    <= '0;
            ld_ready_q    <= 1'b0;
            load_done_q   <= 1'b0;
            bias_loaded_q <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state)
                ST_IDLE, ST_VALID: begin
                    if (bus.load_start) begin
                        n_lat         <= load_clamped;
                        bias_loaded_q <= 1'b0;
                        if (load_clamped == '0) begin
                            state       <= ST_DONE;
                            num_loaded  <= '0;
                            load_done_q <= 1'b1;
                        end else begin
                            state      <= ST_LOAD;
                            wr_ptr     <= '0;
                            ld_ready_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_fire) begin
                        if (last_wr) begin
                            state       <= ST_DONE;
                            ld_ready_q  <= 1'b0;
                            load_done_q <= 1'b1;
                            num_loaded  <= n_lat;
                        end else begin
                            // The clamp keeps the last write at DEPTH-1, so
                            // the pointer never wraps.
                            wr_ptr <= wr_ptr + ONE_A;
                        end
                    end
                end
                ST_DONE: begin
                    if (n_lat != '0) begin
                        state         <= ST_VALID;
                        bias_loaded_q <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // RAM port mux: a load write or a bias read, never both in one cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        bus.mem_cs    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        if (wr_fire) begin
            bus.mem_cs    = 1'b1;
            bus.mem_we    = 1'b1;
            bus.mem_addr  = wr_ptr;
            bus.mem_wdata = bus.ld_data;
        end else if (rd_fire) begin
            bus.mem_cs   = 1'b1;
            bus.mem_addr = bus.rd_addr;
        end
    end

    assign bus.ld_ready    = ld_ready_q;
    assign bus.load_done   = load_done_q;
    assign bus.bias_loaded = bias_loaded_q;
    assign bus.rd_ready    = bias_loaded_q;

    bias_buf_ctrl_rd_pipe #(
        .DW      (DW),
        .N_DELAY (N_DELAY)
    ) u_rd_pipe (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (rd_fire),
        .in_oob    (rd_oob),
        .mem_rdata (bus.mem_rdata),
        .rd_valid  (bus.rd_valid),
        .rd_data   (bus.rd_data)
    );

endmodule

// File: tb/tb_bias_buf_ctrl.sv
// Self-checking bench for bias_buf_ctrl: a behavioural RAM, a table model of
// what was loaded and a scoreboard of expected read responses.
module tb_bias_buf_ctrl #(
    parameter int N_DELAY = 1
);

    localparam int DW    = 128;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rstn;

    bias_buf_ctrl_if #(.DW(DW), .AW(AW)) bus ();

    bias_buf_ctrl #(
        .DW      (DW),
        .AW      (AW),
        .DEPTH   (DEPTH),
        .N_DELAY (N_DELAY)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM with N_DELAY read latency.
    logic [DW-1:0] ram   [DEPTH];
    logic [DW-1:0] rpipe [N_DELAY];

    always @(posedge clk) begin
        if (bus.mem_cs && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        rpipe[0] <= (bus.mem_cs && !bus.mem_we) ? ram[bus.mem_addr] : '0;
        for (int i = 1; i < N_DELAY; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bus.mem_rdata = rpipe[N_DELAY-1];

    // Reference model state
    int            total = 0;
    int            bad   = 0;
    int            cyc   = 0;
    int            wr_count = 0;
    logic [DW-1:0] model_mem [DEPTH];
    int            model_n = 0;
    bit            model_loaded = 1'b0;   // reads should be accepted
    bit            model_ld = 1'b0;       // load words should be accepted
    int            wr_idx = 0;
    bit            mon_en = 1'b0;
    rsp_t          sb[$];
    bit            exp_wr;
    bit            exp_rd;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_word(input int idx);
        logic [7:0] lo;
        lo = idx[7:0];
        return {$urandom(), $urandom(), $urandom(), 24'($urandom()), lo};
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Cycle monitor: RAM-port legality and read responses against the model.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_wr = model_ld && bus.ld_valid;
            exp_rd = model_loaded && bus.rd_req;
            if (bus.mem_cs && bus.mem_we) wr_count <= wr_count + 1;
            check("ld_ready", bus.ld_ready, model_ld);
            check("rd_ready", bus.rd_ready, model_loaded);
            check("mem_cs", bus.mem_cs, exp_wr || exp_rd);
            check("mem_we", bus.mem_we, exp_wr);
            if (exp_wr) begin
                check("wr_addr", bus.mem_addr, wr_idx);
                check("wr_data", bus.mem_wdata, bus.ld_data);
            end
            if (exp_rd) check("rd_mem_addr", bus.mem_addr, bus.rd_addr);
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check("rd_valid", bus.rd_valid, 1'b1);
                check("rd_data", bus.rd_data, sb[0].data);
                void'(sb.pop_front());
            end else begin
                check("rd_valid_idle", bus.rd_valid, 1'b0);
            end
            if (exp_rd)
                sb.push_back('{cyc + N_DELAY,
                               (int'(bus.rd_addr) < model_n) ? model_mem[bus.rd_addr] : '0});
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_ld_ready"}, bus.ld_ready, 1'b0);
        check({tag, "_load_done"}, bus.load_done, 1'b0);
        check({tag, "_bias_loaded"}, bus.bias_loaded, 1'b0);
        check({tag, "_rd_ready"}, bus.rd_ready, 1'b0);
        check({tag, "_rd_valid"}, bus.rd_valid, 1'b0);
        check({tag, "_rd_data"}, bus.rd_data, '0);
        check({tag, "_mem_cs"}, bus.mem_cs, 1'b0);
        check({tag, "_mem_we"}, bus.mem_we, 1'b0);
        check({tag, "_mem_addr"}, bus.mem_addr, '0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, '0);
    endtask

    // Load a table; optional stalls, optional ignored traffic during the
    // load, optional read in the same cycle as load_start.
    task automatic do_load(input int num, input bit stall, input bit noise, input bit rd_first);
        int n, idx, base, budget, t0;
        n    = (num > DEPTH) ? DEPTH : num;
        base = wr_count;
        t0   = cyc;
        bus.load_start = 1'b1;
        bus.load_num   = (AW+1)'(num);
        if (rd_first) begin
            bus.rd_req  = 1'b1;
            bus.rd_addr = '0;
        end
        step();
        bus.load_start = 1'b0;
        bus.rd_req     = 1'b0;
        model_loaded   = 1'b0;
        model_ld       = (n > 0);
        idx    = 0;
        budget = 0;
        while (idx < n && budget < 400) begin
            bus.ld_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.ld_data  = rand_word(idx);
            wr_idx       = idx;
            if (noise) begin
                bus.rd_req     = 1'($urandom_range(0, 1));
                bus.rd_addr    = AW'($urandom());
                bus.load_start = 1'($urandom_range(0, 1));
                bus.load_num   = (AW+1)'($urandom());
            end
            if (bus.ld_valid) begin
                model_mem[idx] = bus.ld_data;
                idx++;
            end
            step();
            budget++;
        end
        check("load_budget", budget < 400, 1'b1);
        // DONE cycle: an extra offered word must be refused.
        model_ld       = 1'b0;
        bus.rd_req     = 1'b0;
        bus.load_start = 1'b0;
        bus.ld_valid   = 1'b1;
        bus.ld_data    = rand_word(8'hEE);
        check("load_done_pulse", bus.load_done, 1'b1);
        check("loaded_in_done", bus.bias_loaded, 1'b0);
        if (!stall && !noise) check("done_cycle", cyc - t0, n + 1);
        step();
        bus.ld_valid = 1'b0;
        model_n      = n;
        model_loaded = (n > 0);
        check("load_done_end", bus.load_done, 1'b0);
        check("bias_loaded", bus.bias_loaded, (n > 0));
        check("write_count", wr_count - base, n);
    endtask

    task automatic do_reads(input int cnt, input bit seq);
        for (int i = 0; i < cnt; i++) begin
            bus.rd_req  = 1'b1;
            bus.rd_addr = seq ? AW'(i) : AW'($urandom());
            step();
        end
        bus.rd_req = 1'b0;
        repeat (N_DELAY + 1) step();
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic read_one(input int a);
        bus.rd_req  = 1'b1;
        bus.rd_addr = AW'(a);
        step();
        bus.rd_req = 1'b0;
        repeat (N_DELAY + 1) step();
        check("sb_drained_one", sb.size(), 0);
    endtask

    task automatic apply_reset();
        rstn         = 1'b0;
        model_ld     = 1'b0;
        model_loaded = 1'b0;
        model_n      = 0;
        bus.ld_valid = 1'b0;
        bus.rd_req   = 1'b0;
        bus.load_start = 1'b0;
        sb.delete();
        #1;
        check_zero("rst_mid");
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;
        rstn           = 1'b0;
        bus.load_start = 1'b0;
        bus.load_num   = '0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = '0;
        bus.rd_req     = 1'b0;
        bus.rd_addr    = '0;
        repeat (3) step();
        check_zero("reset");
        rstn   = 1'b1;
        mon_en = 1'b1;

        // Reads before any table is loaded are dropped.
        do_reads(4, 1'b0);

        // Full load, then every word read back-to-back.
        do_load(16, 1'b0, 1'b0, 1'b0);
        do_reads(16, 1'b1);

        // Partial load with stalls; in-range and out-of-range reads.
        do_load(5, 1'b1, 1'b0, 1'b0);
        read_one(3);
        read_one(7);
        do_reads(12, 1'b0);

        // Clamp to DEPTH, then an empty table.
        do_load(20, 1'b0, 1'b0, 1'b0);
        do_reads(8, 1'b0);
        do_load(0, 1'b0, 1'b0, 1'b0);
        do_reads(4, 1'b0);

        // Read and load_start in the same VALID cycle.
        do_load(16, 1'b0, 1'b0, 1'b0);
        do_load(4, 1'b0, 1'b0, 1'b1);
        do_reads(16, 1'b1);

        // Reads and load_start during LOAD are ignored.
        do_load(9, 1'b1, 1'b1, 1'b0);
        do_reads(16, 1'b1);

        // Reset with a read in flight.
        bus.rd_req  = 1'b1;
        bus.rd_addr = 4'd2;
        step();
        bus.rd_req = 1'b0;
        apply_reset();
        do_reads(3, 1'b0);

        // Reset after 3 of 8 load words, then a clean reload.
        bus.load_start = 1'b1;
        bus.load_num   = 5'd8;
        step();
        bus.load_start = 1'b0;
        model_ld       = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = rand_word(i);
            wr_idx       = i;
            step();
        end
        apply_reset();
        do_reads(3, 1'b0);
        do_load(8, 1'b0, 1'b0, 1'b0);
        do_reads(16, 1'b1);
        do_reads(20, 1'b0);

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

endmodule
